// File: rtl/jtkcpu_bus_pkg.sv
// Shared definitions for the CPU bus target: state encodings, parameter
// defaults and counter preload helper.
package jtkcpu_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    localparam int unsigned WAIT_MIN_DEFAULT = 0;
    localparam int unsigned TOUT_DEFAULT     = 255;

    // Counters terminate on the tick that finds them at zero, so an N-tick
    // interval is preloaded with N-1.
    function automatic logic [7:0] ticks_preload(input int unsigned ticks);
        return 8'(ticks - 1);
    endfunction

endpackage

// File: rtl/jtkcpu_bustgt_cnt.sv
// 8-bit loadable down-counter: load is ungated, decrement is cen-gated and
// saturates at zero.
module jtkcpu_bustgt_cnt
    import jtkcpu_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (cen && dec && count != '0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/jtkcpu_bustgt.sv
// CPU bus target: turns a CPU address-strobe cycle into a backend request,
// inserts optional wait states and raises a bus error on backend timeout.
module jtkcpu_bustgt
    import jtkcpu_bus_pkg::*;
#(
    parameter int unsigned WAIT_MIN = WAIT_MIN_DEFAULT,
    parameter int unsigned TOUT     = TOUT_DEFAULT
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        cpu_as,
    input  logic [23:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        dtack,
    output logic        berr,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] WAIT_LOAD = (WAIT_MIN == 0) ? 8'd0 : ticks_preload(WAIT_MIN);
    localparam logic [7:0] TOUT_LOAD = ticks_preload(TOUT);

    logic [1:0] state;
    logic       as_was_low;
    logic       ack_pend;
    logic       start;
    logic       timeout;
    logic       wait_load;
    logic       wait_zero;
    logic       tout_zero;

    // as_was_low resets to 0 so a strobe held high across reset is not a new edge.
    assign start     = (state == ST_IDLE) && cen && cpu_as && as_was_low;
    assign timeout   = (state == ST_REQ) && !ack_pend && !mem_ack && cen && tout_zero;
    assign wait_load = (state == ST_REQ) && ack_pend;

    jtkcpu_bustgt_cnt u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .dec      (state == ST_HOLD),
        .zero     (wait_zero)
    );

    jtkcpu_bustgt_cnt u_tout (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .load     (start),
        .load_val (TOUT_LOAD),
        .dec      ((state == ST_REQ) && !ack_pend),
        .zero     (tout_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            as_was_low <= 1'b0;
            ack_pend   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            cpu_din    <= '0;
            dtack      <= 1'b0;
            berr       <= 1'b0;
        end else begin
            if (cen) begin
                as_was_low <= !cpu_as;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr  <= cpu_addr;
                        mem_we    <= cpu_we;
                        mem_wdata <= cpu_dout;
                        mem_req   <= 1'b1;
                        ack_pend  <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The ack is captured on its own edge; the request drops one edge later.
                    if (ack_pend) begin
                        mem_req  <= 1'b0;
                        ack_pend <= 1'b0;
                        if (WAIT_MIN != 0) begin
                            state <= ST_HOLD;
                        end else begin
                            state <= ST_ACK;
                            dtack <= 1'b1;
                        end
                    end else if (mem_ack) begin
                        ack_pend <= 1'b1;
                        if (!mem_we) begin
                            cpu_din <= mem_rdata;
                        end
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        cpu_din <= 8'hFF;
                        berr    <= 1'b1;
                        dtack   <= 1'b1;
                        state   <= ST_ACK;
                    end
                end
                ST_HOLD: begin
                    if (cen && wait_zero) begin
                        dtack <= 1'b1;
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (cen && !cpu_as) begin
                        dtack <= 1'b0;
                        berr  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtkcpu_bustgt.sv
// Randomized bench for jtkcpu_bustgt: each access is planned as per-cycle input
// tables, and event edges are predicted from the tables before replay.
module tb_jtkcpu_bustgt;

    localparam int L        = 96;
    localparam int TOUT_CFG = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        cpu_as    [2];
    logic [23:0] cpu_addr  [2];
    logic        cpu_we    [2];
    logic [7:0]  cpu_dout  [2];
    logic [7:0]  cpu_din   [2];
    logic        dtack     [2];
    logic        berr      [2];
    logic        mem_req   [2];
    logic [23:0] mem_addr  [2];
    logic        mem_we    [2];
    logic [7:0]  mem_wdata [2];
    logic [7:0]  mem_rdata [2];
    logic        mem_ack   [2];

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  din_model [2];

    bit          cen_a [L];
    bit          as_a  [L];
    bit          ack_a [L];
    logic [7:0]  rd_a  [L];

    always #5 clk = ~clk;

    jtkcpu_bustgt #(.WAIT_MIN(0), .TOUT(TOUT_CFG)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .cpu_as(cpu_as[0]), .cpu_addr(cpu_addr[0]), .cpu_we(cpu_we[0]), .cpu_dout(cpu_dout[0]),
        .cpu_din(cpu_din[0]), .dtack(dtack[0]), .berr(berr[0]),
        .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0])
    );

    jtkcpu_bustgt #(.WAIT_MIN(2), .TOUT(TOUT_CFG)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .cpu_as(cpu_as[1]), .cpu_addr(cpu_addr[1]), .cpu_we(cpu_we[1]), .cpu_dout(cpu_dout[1]),
        .cpu_din(cpu_din[1]), .dtack(dtack[1]), .berr(berr[1]),
        .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        cen = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cpu_as[k]  = 1'b0;
            mem_ack[k] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input int k);
        chk("rst_mem_req", 32'(mem_req[k]), 32'd0);
        chk("rst_dtack", 32'(dtack[k]), 32'd0);
        chk("rst_berr", 32'(berr[k]), 32'd0);
        chk("rst_mem_we", 32'(mem_we[k]), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr[k]), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata[k]), 32'd0);
        chk("rst_cpu_din", 32'(cpu_din[k]), 32'd0);
    endtask

    // mode: 0 random, 1 read ack after 3 clk, 2 write ack after 2 clk,
    // 3 no ack (timeout), 4 ack on the timeout edge
    task automatic run_txn(input int k, input int mode);
        int         w, s, a, t, r, f, h, drop, cnt, tries;
        bit         valid, we, all_cen, req_exp, dt_exp;
        logic [23:0] addr;
        logic [7:0] wd, exp_din;
        w = (k == 0) ? 0 : 2;
        tries = 0;
        do begin
            all_cen = (mode != 0) || (tries >= 20);
            tries++;
            for (int j = 0; j < L; j++) begin
                cen_a[j] = all_cen ? 1'b1 : ($urandom_range(0, 3) != 0);
                ack_a[j] = 1'b0;
                rd_a[j]  = 8'($urandom);
            end
            s = (mode != 0) ? 0 : int'($urandom_range(0, 3));
            for (int j = 0; j < s; j++) cen_a[j] = 1'b0;
            cen_a[s] = 1'b1;
            t = L;
            cnt = 0;
            for (int j = s + 1; j < L; j++) begin
                if (cen_a[j]) begin
                    cnt++;
                    if (cnt == TOUT_CFG) begin
                        t = j;
                        break;
                    end
                end
            end
            case (mode)
                1: a = s + 3;
                2: a = s + 2;
                3: a = L;
                4: a = t;
                default: begin
                    cnt = int'($urandom_range(0, 9));
                    a = (cnt < 2) ? L : (cnt < 4) ? t : s + int'($urandom_range(1, 8));
                end
            endcase
            valid = (a < L) && (a <= t);
            if (a < L) ack_a[a] = 1'b1;
            for (int j = 0; j < L; j++) begin
                if ((j <= s || j >= (valid ? a + 2 : t + 1)) && $urandom_range(0, 7) == 0)
                    ack_a[j] = 1'b1;
            end
            drop = s + int'($urandom_range(1, 30));
            for (int j = 0; j < L; j++) as_a[j] = (j < drop);
            r = L;
            if (!valid) begin
                r = t;
            end else if (w == 0) begin
                r = a + 1;
            end else begin
                h = a + 1;
                cnt = 0;
                for (int j = h + 1; j < L; j++) begin
                    if (cen_a[j]) begin
                        cnt++;
                        if (cnt == w) begin
                            r = j;
                            break;
                        end
                    end
                end
            end
            f = L;
            for (int j = r + 1; j < L; j++) begin
                if (cen_a[j] && !as_a[j]) begin
                    f = j;
                    break;
                end
            end
        end while (f >= L - 1 || t >= L);

        addr = 24'($urandom);
        we   = 1'($urandom_range(0, 1));
        wd   = 8'($urandom);
        if (mode == 1) begin
            addr = 24'h01_2345;
            we = 1'b0;
            rd_a[a] = 8'hA5;
        end else if (mode == 2) begin
            we = 1'b1;
            wd = 8'h3C;
        end else if (mode >= 3) begin
            we = 1'b0;
        end
        exp_din = !valid ? 8'hFF : (we ? din_model[k] : rd_a[a]);

        for (int j = 0; j <= f + 1; j++) begin
            @(negedge clk);
            cen          = cen_a[j];
            cpu_as[k]    = as_a[j];
            mem_ack[k]   = ack_a[j];
            mem_rdata[k] = rd_a[j];
            if (j <= s) begin
                cpu_addr[k] = addr;
                cpu_we[k]   = we;
                cpu_dout[k] = wd;
            end else begin
                cpu_addr[k] = 24'($urandom);
                cpu_we[k]   = 1'($urandom_range(0, 1));
                cpu_dout[k] = 8'($urandom);
            end
            @(posedge clk);
            #1;
            req_exp = (j >= s) && (j <= (valid ? a : t - 1));
            dt_exp  = (j >= r) && (j < f);
            chk("mem_req", 32'(mem_req[k]), 32'(req_exp));
            chk("dtack", 32'(dtack[k]), 32'(dt_exp));
            chk("berr", 32'(berr[k]), 32'(dt_exp && !valid));
            if (req_exp) begin
                chk("mem_addr", 32'(mem_addr[k]), 32'(addr));
                chk("mem_we", 32'(mem_we[k]), 32'(we));
                chk("mem_wdata", 32'(mem_wdata[k]), 32'(wd));
            end
            if (dt_exp || j == f + 1)
                chk("cpu_din", 32'(cpu_din[k]), 32'(exp_din));
        end
        mem_ack[k] = 1'b0;
        din_model[k] = exp_din;
    endtask

    task automatic reset_mid_req();
        @(negedge clk);
        cen = 1'b1;
        cpu_as[0]   = 1'b1;
        cpu_addr[0] = 24'hAB_CDEF;
        cpu_we[0]   = 1'b0;
        cpu_dout[0] = 8'h55;
        mem_ack[0]  = 1'b0;
        @(posedge clk);
        #1;
        chk("rmr_req_up", 32'(mem_req[0]), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmr_req_async", 32'(mem_req[0]), 32'd0);
        chk("rmr_dtack_async", 32'(dtack[0]), 32'd0);
        chk("rmr_addr_async", 32'(mem_addr[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        din_model[0] = 8'h00;
        din_model[1] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cen = 1'b1;
            @(posedge clk);
            #1;
            chk("rmr_no_restart", 32'(mem_req[0]), 32'd0);
            chk("rmr_no_dtack", 32'(dtack[0]), 32'd0);
        end
        settle();
    endtask

    initial begin
        rst_n = 1'b0;
        cen   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cpu_as[k]    = 1'b0;
            cpu_addr[k]  = '0;
            cpu_we[k]    = 1'b0;
            cpu_dout[k]  = '0;
            mem_rdata[k] = '0;
            mem_ack[k]   = 1'b0;
            din_model[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0);
        check_reset_state(1);
        @(negedge clk);
        rst_n = 1'b1;
        settle();

        run_txn(0, 1);
        run_txn(1, 2);
        run_txn(0, 3);
        run_txn(0, 4);
        run_txn(1, 3);
        run_txn(1, 4);
        reset_mid_req();
        for (int i = 0; i < 40; i++)
            run_txn(int'($urandom_range(0, 1)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
